// File: rtl/keccak_perm_sequencer.sv
// keccak_perm_sequencer: owns the reset of the masked Keccak-p core.
// It accepts one shared state, releases the core for NR rounds while
// feeding it fresh randomness, then holds the shared result until it is
// taken.
// Optional build macro: KECCAK_SEQ_CLEAR_EN. When it is defined, the share
// registers are wiped after the output handshake, and in_reg is also wiped
// on abort.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | core held in reset, waiting for an input job
// LOAD   | core held in reset/load, samples core_indata (one cycle)
// RUN    | core released, one round and one PRNG word per cycle
// HOLD   | result captured, core back in reset, waiting for out_ready
module keccak_perm_sequencer #(
  parameter int W   = 8,
  parameter int B   = 25 * W,
  parameter int SIN = 2,
  parameter int NR  = 12 + 2 * $clog2(W),
  parameter int RW  = ((SIN * SIN - SIN) / 2) * B
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SIN*B-1:0] in_data_i,
  input  logic             rand_valid_i,
  input  logic [RW-1:0]    rand_in_i,
  output logic             rand_req_o,
  output logic             core_rst_o,
  output logic [SIN*B-1:0] core_indata_o,
  output logic [RW-1:0]    core_rand_o,
  input  logic             core_ready_i,
  input  logic [SIN*B-1:0] core_outdata_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SIN*B-1:0] out_data_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int CW = $clog2(NR);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_e;

  state_e           state_q, state_d;
  logic [SIN*B-1:0] in_reg_q, in_reg_d;
  logic [SIN*B-1:0] out_reg_q, out_reg_d;
  logic [CW-1:0]    rcnt_q, rcnt_d;
  logic             err_q, err_d;

  logic last_round;
  logic abort;
  logic capture;

  // Round bookkeeping: a missing PRNG word wins over a completed final round.
  always_comb begin
    last_round = (rcnt_q == CW'(NR - 1));
    abort      = (state_q == S_RUN) &&
                 (!rand_valid_i || (last_round && !core_ready_i));
    capture    = (state_q == S_RUN) && rand_valid_i && last_round && core_ready_i;
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      in_reg_q  <= '0;
      out_reg_q <= '0;
      rcnt_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_reg_q  <= in_reg_d;
      out_reg_q <= out_reg_d;
      rcnt_q    <= rcnt_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid_i) state_d = S_LOAD;
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (abort)        state_d = S_IDLE;
        else if (capture) state_d = S_HOLD;
      end
      S_HOLD: if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: share capture, round counter, sticky error.
  always_comb begin
    in_reg_d  = in_reg_q;
    out_reg_d = out_reg_q;
    rcnt_d    = rcnt_q;
    err_d     = err_q;
    if (state_q == S_IDLE && in_valid_i) begin
      in_reg_d = in_data_i;
      err_d    = 1'b0;
    end
    if (state_q == S_LOAD) rcnt_d = '0;
    // The counter stops at NR-1; the job always leaves RUN on that cycle.
    if (state_q == S_RUN && !last_round) rcnt_d = rcnt_q + CW'(1);
    if (abort) err_d = 1'b1;
    if (capture) out_reg_d = core_outdata_i;
`ifdef KECCAK_SEQ_CLEAR_EN
    if (state_q == S_HOLD && out_ready_i) begin
      in_reg_d  = '0;
      out_reg_d = '0;
    end
    if (abort) in_reg_d = '0;
`endif
  end

  // Moore outputs decoded from the state, plus the randomness pass-through.
  always_comb begin
    in_ready_o    = (state_q == S_IDLE);
    core_rst_o    = (state_q != S_RUN);
    rand_req_o    = (state_q == S_RUN);
    out_valid_o   = (state_q == S_HOLD);
    busy_o        = (state_q == S_LOAD) || (state_q == S_RUN);
    err_o         = err_q;
    core_indata_o = in_reg_q;
    out_data_o    = out_reg_q;
    core_rand_o   = rand_in_i;
  end

endmodule

// File: doc/keccak_perm_sequencer.md
# keccak_perm_sequencer

Sequencer for the masked low-latency Keccak-p core: accepts a shared input state over a valid/ready handshake and holds the core in reset between jobs. It releases the core for exactly NR rounds while streaming fresh randomness into it, then captures the shared output into a hold register and presents it over a valid/ready handshake. It sits between the system bus/PRNG and the core, and is the only block allowed to drive the core's reset.

## Interface
- B, 200, permutation width in bits (25·W)
- W, 8, lane width; NR = 12 + 2·log2(W) rounds (18 at default)
- SIN, 2, input/output share count (order + 1)
- RW, ((SIN·SIN−SIN)/2)·B, fresh-randomness width per round
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- in_valid / in_ready  in / out  1 each  input job handshake
- in_data  in  SIN·B  shares concatenated, share 0 in LSBs
- rand_valid  in  1  PRNG word available this cycle
- rand_in  in  RW  PRNG word
- rand_req  out  1  PRNG word consumed this cycle
- core_rst  out  1  active-high reset/load to core
- core_indata  out  SIN·B  registered input shares to core
- core_rand  out  RW  randomness to core, combinational from rand_in
- core_ready  in  1  core's done flag
- core_outdata  in  SIN·B  core output shares
- out_valid / out_ready  out / in  1 each  output handshake
- out_data  out  SIN·B  registered output shares
- busy  out  1  high in LOAD and RUN
- err  out  1  sticky job-abort flag

## Operation
- States: IDLE, LOAD, RUN, HOLD; reset enters IDLE.
- IDLE: in_ready=1, core_rst=1. On in_valid, capture in_data into in_reg, clear err, go to LOAD.
- LOAD (exactly 1 cycle): core_rst=1 and core_indata=in_reg; the core samples its input. Clear rcnt, go to RUN.
- RUN: core_rst=0, rand_req=1, rcnt increments each cycle.
  - rand_valid=0 in any RUN cycle aborts the job: set err, go to IDLE, core_rst=1 next cycle, no out_valid.
  - When rcnt reaches NR−1, core_ready must be 1 in that cycle. If so, capture core_outdata into out_reg and go to HOLD. Otherwise set err and go to IDLE.
- HOLD: out_valid=1, core_rst=1, in_ready=0. On out_ready, go to IDLE.
- The core never stalls, so randomness underflow is fatal for the job; there is no retry.
- rcnt is $clog2(NR) bits wide and never wraps; it is cleared in LOAD.
- Simultaneous events:
  - rand_valid=0 in the final RUN cycle: abort takes priority over capture.
  - in_valid during HOLD: ignored, in_ready=0.
- Reset mid-job: immediate return to IDLE, all registers cleared, no output.

## Timing
- Reset values:
  - in_ready=1, core_rst=1
  - rand_req=0, out_valid=0, busy=0, err=0
  - out_data=0, core_indata=0
- Accept at cycle 0; LOAD at cycle 1; RUN at cycles 2..NR+1; out_valid first high at cycle NR+2 (20 at default).
- Back-to-back jobs: handshake in HOLD at cycle t puts the block in IDLE at t+1, so it can accept at t+1. Minimum job period is NR+3 cycles.
- rand_req is high for exactly NR consecutive cycles per successful job.

## Configuration
- KECCAK_SEQ_CLEAR_EN
  - Defined: out_reg and in_reg are zeroed on the cycle after the out_valid handshake, and in_reg is also zeroed on abort. No shares linger in the registers.
  - Undefined: both registers retain their last contents; out_data holds its last value after the handshake.

## Test plan
- Reset low mid-RUN (cycle 7) → next cycle busy=0, core_rst=1, out_valid=0, err=0.
- Single job, rand_valid always 1, core model raises core_ready on round 18 → rand_req high for 18 cycles, out_valid at cycle 20, out_data equals core_outdata sampled at cycle 19.
- rand_valid dropped at RUN cycle 5 → err=1, out_valid never asserts, in_ready=1 on the next cycle; err clears on the next accept.
- core_ready low at rcnt=17 → err=1, return to IDLE, no capture.
- out_ready held low 10 cycles, in_valid high throughout → out_valid and out_data stable, in_ready=0; after the handshake the next job is accepted one cycle later.
- With KECCAK_SEQ_CLEAR_EN defined → out_data=0 one cycle after the handshake; without it → out_data unchanged.
